control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle instruction sequencer that sits directly upstream of `Datapath_Unit`. Fetches 16-bit instructions from a synchronous-read instruction memory, decodes them, and drives every datapath control input (register-file, ALU, data-memory and write-back mux selects). It samples the datapath `zero` flag to resolve conditional jumps. One instruction completes every 3 cycles; HALT parks the sequencer until reset.

## Interface
- `PC_W`, default 8: program-counter / instruction-address width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_addr` out `PC_W`: instruction address, equals PC.
- `i_rd` out 1: instruction read strobe.
- `i_data` in 16: instruction word, valid the cycle after `i_rd`, held until the next read.
- `zero` in 1: datapath zero flag, combinational from register-file port 1.
- `alu_op` out 2: 00 pass A, 01 A+B, 10 A−B.
- `mux1_sel` out 2: 00 ALU, 01 data memory, 10 sign-extended constant.
- `register_const` out 8: constant for LOADC.
- `D_addr` out 8; `D_rd`, `D_wr` out 1: data-memory controls.
- `reg_write_en` out 1; `reg_write_addr` out 4: register-file write controls.
- `reg_read_addr_1`, `reg_read_addr_2` out 4; `reg_read_en_1`, `reg_read_en_2` out 1: register-file read controls.
- `pc` out `PC_W`: current PC, for debug.
- `halted` out 1: high while in HALT.

## Operation
- Instruction format: `op`=[15:12], `ra`=[11:8], `rb`=[7:4], `rc`=[3:0], `k8`=[7:0].
- Opcodes:
  - 0000 LOAD ra←M[k8]
  - 0001 STORE M[k8]←ra
  - 0010 ADD ra←rb+rc
  - 0011 LOADC ra←sext(k8)
  - 0100 SUB ra←rb−rc
  - 0101 JMPZ: if ra==0, PC←PC+sext(k8)
  - 0110 JMP: PC←k8
  - 1111 HALT
  - all others are a NOP and return to FETCH.
- States: FETCH, DECODE, LOAD, STORE, ADD, SUB, LOADC, JMPZ, JMP, HALT.
- FETCH: `i_rd`=1, `i_addr`=PC → DECODE.
- DECODE: IR←`i_data`; PC←PC+1 (mod 2^`PC_W`). Next state is selected from `i_data`[15:12].
- Execute states last one cycle each, then return to FETCH. Outputs are a Moore decode of state and IR:
  - LOAD: `D_rd`=1, `D_addr`=k8, `mux1_sel`=01, `reg_write_en`=1, `reg_write_addr`=ra.
  - STORE: `D_wr`=1, `D_addr`=k8, `reg_read_en_1`=1, `reg_read_addr_1`=ra.
  - ADD/SUB: `reg_read_en_1`=`reg_read_en_2`=1, `reg_read_addr_1`=rb, `reg_read_addr_2`=rc, `alu_op`=01/10, `mux1_sel`=00, `reg_write_en`=1, `reg_write_addr`=ra.
  - LOADC: `register_const`=k8, `mux1_sel`=10, `reg_write_en`=1, `reg_write_addr`=ra.
  - JMPZ: `reg_read_en_1`=1, `reg_read_addr_1`=ra, `alu_op`=00. `zero` is sampled at the clock edge ending the state; if it is 1, PC←PC+sext(k8) (PC is already incremented, arithmetic wraps at `PC_W` bits).
  - JMP: PC←k8 zero-extended.
  - HALT: self-loop, `halted`=1, `i_rd`=0.
- Every control output not listed for a state is 0. `reg_write_en` and `D_wr` are single-cycle pulses, because the downstream storage writes while they are high.
- `register_const`, `D_addr` and all address outputs are 0 outside the states that use them.

## Timing
- Reset (asynchronous): state=FETCH, PC=0, IR=0, `halted`=0, and all control outputs 0 immediately. First `i_rd` occurs in the first cycle after `rst` falls.
- Reset mid-instruction aborts it: a `D_wr` or `reg_write_en` pulse drops combinationally and the PC update is discarded.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), taken or not. HALT is exited only by `rst`.
- PC wrap: 0xFF+1 → 0x00. JMPZ with k8=0x80 from PC 0x10 gives 0x90 (mod 256).

## Structure
- Shared package `cpu_pkg` holds: opcode constants, state enum, `alu_op` codes (PASS/ADD/SUB), `mux1_sel` codes (ALU/MEM/CONST), and instruction field-position constants. `Datapath_Unit` users import the same codes.
- One sub-module, `program_counter`: register with synchronous `inc`, `load_rel` (signed 8-bit offset) and `load_abs` controls, plus asynchronous `rst`.
- The FSM and output decode stay in `control_unit`.

## Test plan
- `rst` pulse during the STORE execute cycle → `D_wr` drops to 0 within the same cycle, `pc`=0, next `i_addr`=0 with `i_rd`=1.
- ROM[0]=0x337F (LOADC R3,0x7F) → cycle 3: `mux1_sel`=10, `register_const`=0x7F, `reg_write_en`=1, `reg_write_addr`=3, `pc`=1. Cycle 4: FETCH at `i_addr`=1.
- 0x2123 (ADD R1,R2,R3) → `alu_op`=01, `reg_read_addr_1`=2, `reg_read_addr_2`=3, `reg_write_addr`=1, `reg_write_en` high exactly 1 cycle. Repeat with 0x4123 → `alu_op`=10.
- 0x54FD (JMPZ R4,−3) at PC 5: `zero`=1 → next `i_addr`=3; `zero`=0 → next `i_addr`=6.
- 0x1210 (STORE R2,0x10) → `D_wr`=1, `D_addr`=0x10, `reg_read_addr_1`=2, `reg_write_en`=0. Then 0x0310 (LOAD R3,0x10) → `D_rd`=1, `mux1_sel`=01, `reg_write_addr`=3.
- 0x7ABC (undefined opcode) → all controls 0 and PC advances by 1. Then 0xF000 (HALT) → `halted`=1 and `i_rd`=0 for 20 cycles, until `rst`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared codes for the sequencer and the datapath: opcodes, FSM states,
// ALU / write-back select encodings and instruction field positions.
package cpu_pkg;
    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LOADC = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD,
        S_SUB, S_LOADC, S_JMPZ, S_JMP, S_HALT
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [1:0] MUX_ALU   = 2'b00;
    localparam logic [1:0] MUX_MEM   = 2'b01;
    localparam logic [1:0] MUX_CONST = 2'b10;

    localparam int OP_MSB = 15, OP_LSB = 12;
    localparam int RA_MSB = 11, RA_LSB = 8;
    localparam int RB_MSB = 7,  RB_LSB = 4;
    localparam int RC_MSB = 3,  RC_LSB = 0;
    localparam int K8_MSB = 7,  K8_LSB = 0;
endpackage

// File: rtl/control_unit_if.sv
// Instruction-memory and datapath control bundle between control_unit
// (master) and the memory / Datapath_Unit side (slave).
interface control_unit_if #(parameter int PC_W = 8);
    logic [PC_W-1:0] i_addr;
    logic            i_rd;
    logic [15:0]     i_data;
    logic            zero;
    logic [1:0]      alu_op;
    logic [1:0]      mux1_sel;
    logic [7:0]      register_const;
    logic [7:0]      D_addr;
    logic            D_rd;
    logic            D_wr;
    logic            reg_write_en;
    logic [3:0]      reg_write_addr;
    logic [3:0]      reg_read_addr_1;
    logic [3:0]      reg_read_addr_2;
    logic            reg_read_en_1;
    logic            reg_read_en_2;
    logic [PC_W-1:0] pc;
    logic            halted;

    modport master (
        output i_addr, i_rd, alu_op, mux1_sel, register_const, D_addr, D_rd, D_wr,
               reg_write_en, reg_write_addr, reg_read_addr_1, reg_read_addr_2,
               reg_read_en_1, reg_read_en_2, pc, halted,
        input  i_data, zero
    );

    modport slave (
        input  i_addr, i_rd, alu_op, mux1_sel, register_const, D_addr, D_rd, D_wr,
               reg_write_en, reg_write_addr, reg_read_addr_1, reg_read_addr_2,
               reg_read_en_1, reg_read_en_2, pc, halted,
        output i_data, zero
    );
endinterface

// File: rtl/program_counter.sv
// Program counter with increment, signed 8-bit relative load and absolute load.
module program_counter #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load_rel,
    input  logic            load_abs,
    input  logic [7:0]      offset,
    input  logic [7:0]      target,
    output logic [PC_W-1:0] pc
);
    logic [PC_W+7:0] offset_ext;
    logic [PC_W+7:0] target_ext;

    // Widen first, then slice: works for any PC_W, wider or narrower than 8.
    assign offset_ext = {{PC_W{offset[7]}}, offset};
    assign target_ext = {{PC_W{1'b0}}, target};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load_abs) begin
            pc <= target_ext[PC_W-1:0];
        end else if (load_rel) begin
            pc <= pc + offset_ext[PC_W-1:0];
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end
endmodule

// File: rtl/control_unit.sv
// Three-cycle fetch/decode/execute sequencer driving Datapath_Unit controls.
// Control outputs are registered as the state is entered, so reset clears them at once.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic clk,
    input  logic rst,
    control_unit_if.master bus
);
    state_t          state;
    logic [7:0]      ir_k8;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      op_in;
    logic [3:0]      ra_in;
    logic [3:0]      rb_in;
    logic [3:0]      rc_in;
    logic [7:0]      k8_in;

    assign op_in = bus.i_data[OP_MSB:OP_LSB];
    assign ra_in = bus.i_data[RA_MSB:RA_LSB];
    assign rb_in = bus.i_data[RB_MSB:RB_LSB];
    assign rc_in = bus.i_data[RC_MSB:RC_LSB];
    assign k8_in = bus.i_data[K8_MSB:K8_LSB];

    program_counter #(.PC_W(PC_W)) u_program_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (state == S_DECODE),
        .load_rel (state == S_JMPZ && bus.zero),
        .load_abs (state == S_JMP),
        .offset   (ir_k8),
        .target   (ir_k8),
        .pc       (pc_q)
    );

    assign bus.pc     = pc_q;
    assign bus.i_addr = pc_q;
    // Gated with rst so the strobe is silent while reset is held.
    assign bus.i_rd   = (state == S_FETCH) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir_k8 <= '0;
            bus.alu_op <= ALU_PASS;  bus.mux1_sel <= MUX_ALU;  bus.register_const <= '0;
            bus.D_addr <= '0;  bus.D_rd <= 1'b0;  bus.D_wr <= 1'b0;
            bus.reg_write_en <= 1'b0;  bus.reg_write_addr <= '0;
            bus.reg_read_addr_1 <= '0;  bus.reg_read_addr_2 <= '0;
            bus.reg_read_en_1 <= 1'b0;  bus.reg_read_en_2 <= 1'b0;
            bus.halted <= 1'b0;
        end else begin
            bus.alu_op <= ALU_PASS;  bus.mux1_sel <= MUX_ALU;  bus.register_const <= '0;
            bus.D_addr <= '0;  bus.D_rd <= 1'b0;  bus.D_wr <= 1'b0;
            bus.reg_write_en <= 1'b0;  bus.reg_write_addr <= '0;
            bus.reg_read_addr_1 <= '0;  bus.reg_read_addr_2 <= '0;
            bus.reg_read_en_1 <= 1'b0;  bus.reg_read_en_2 <= 1'b0;
            bus.halted <= 1'b0;
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir_k8 <= k8_in;
                    case (op_in)
                        OP_LOAD: begin
                            state <= S_LOAD;
                            bus.D_rd <= 1'b1;  bus.D_addr <= k8_in;  bus.mux1_sel <= MUX_MEM;
                            bus.reg_write_en <= 1'b1;  bus.reg_write_addr <= ra_in;
                        end
                        OP_STORE: begin
                            state <= S_STORE;
                            bus.D_wr <= 1'b1;  bus.D_addr <= k8_in;
                            bus.reg_read_en_1 <= 1'b1;  bus.reg_read_addr_1 <= ra_in;
                        end
                        OP_ADD, OP_SUB: begin
                            state <= (op_in == OP_ADD) ? S_ADD : S_SUB;
                            bus.alu_op <= (op_in == OP_ADD) ? ALU_ADD : ALU_SUB;
                            bus.reg_read_en_1 <= 1'b1;  bus.reg_read_addr_1 <= rb_in;
                            bus.reg_read_en_2 <= 1'b1;  bus.reg_read_addr_2 <= rc_in;
                            bus.reg_write_en <= 1'b1;  bus.reg_write_addr <= ra_in;
                        end
                        OP_LOADC: begin
                            state <= S_LOADC;
                            bus.register_const <= k8_in;  bus.mux1_sel <= MUX_CONST;
                            bus.reg_write_en <= 1'b1;  bus.reg_write_addr <= ra_in;
                        end
                        OP_JMPZ: begin
                            state <= S_JMPZ;
                            bus.reg_read_en_1 <= 1'b1;  bus.reg_read_addr_1 <= ra_in;
                        end
                        OP_JMP: state <= S_JMP;
                        OP_HALT: begin
                            state <= S_HALT;
                            bus.halted <= 1'b1;
                        end
                        default: state <= S_FETCH;
                    endcase
                end
                S_HALT: begin
                    state <= S_HALT;
                    bus.halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset/NOP/HALT sequences,
// then random programs checked against an instruction-level reference model.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] rom [256];
    logic [7:0]  mpc;

    control_unit_if #(.PC_W(8)) bus ();
    control_unit #(.PC_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.i_rd) bus.i_data <= rom[bus.i_addr];

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] mux1_sel;
        logic [7:0] rconst;
        logic [7:0] d_addr;
        logic       d_rd, d_wr, we;
        logic [3:0] wa, ra1, ra2;
        logic       re1, re2, halted, i_rd;
        logic [7:0] i_addr, pc;
    } ctrl_t;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        ctrl_t       exp;
        logic [7:0]  next_pc;
    } vec_t;

    vec_t tbl [13];

    function automatic ctrl_t sample();
        ctrl_t c;
        c.alu_op = bus.alu_op;  c.mux1_sel = bus.mux1_sel;  c.rconst = bus.register_const;
        c.d_addr = bus.D_addr;  c.d_rd = bus.D_rd;  c.d_wr = bus.D_wr;
        c.we = bus.reg_write_en;  c.wa = bus.reg_write_addr;
        c.ra1 = bus.reg_read_addr_1;  c.ra2 = bus.reg_read_addr_2;
        c.re1 = bus.reg_read_en_1;  c.re2 = bus.reg_read_en_2;
        c.halted = bus.halted;  c.i_rd = bus.i_rd;  c.i_addr = bus.i_addr;  c.pc = bus.pc;
        return c;
    endfunction

    function automatic ctrl_t idle(input logic [7:0] p, input logic rd, input logic h);
        ctrl_t c = '0;
        c.i_addr = p;  c.pc = p;  c.i_rd = rd;  c.halted = h;
        return c;
    endfunction

    function automatic ctrl_t mk(input logic [1:0] alu, input logic [1:0] mux, input logic [7:0] k,
                                 input logic [7:0] da, input logic rd, input logic wr, input logic we,
                                 input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2,
                                 input logic e1, input logic e2, input logic [7:0] p);
        ctrl_t c = idle(p, 1'b0, 1'b0);
        c.alu_op = alu;  c.mux1_sel = mux;  c.rconst = k;  c.d_addr = da;
        c.d_rd = rd;  c.d_wr = wr;  c.we = we;  c.wa = wa;
        c.ra1 = r1;  c.ra2 = r2;  c.re1 = e1;  c.re2 = e2;
        return c;
    endfunction

    // Reference: what the execute cycle of each opcode must show, from the ISA description.
    function automatic ctrl_t model_exec(input logic [15:0] ins, input logic [7:0] p);
        logic [3:0] ra = ins[11:8], rb = ins[7:4], rc = ins[3:0];
        logic [7:0] k  = ins[7:0];
        case (ins[15:12])
            4'h0: return mk(2'd0, 2'd1, 8'h0, k, 1, 0, 1, ra, 4'h0, 4'h0, 0, 0, p);
            4'h1: return mk(2'd0, 2'd0, 8'h0, k, 0, 1, 0, 4'h0, ra, 4'h0, 1, 0, p);
            4'h2: return mk(2'd1, 2'd0, 8'h0, 8'h0, 0, 0, 1, ra, rb, rc, 1, 1, p);
            4'h3: return mk(2'd0, 2'd2, k, 8'h0, 0, 0, 1, ra, 4'h0, 4'h0, 0, 0, p);
            4'h4: return mk(2'd2, 2'd0, 8'h0, 8'h0, 0, 0, 1, ra, rb, rc, 1, 1, p);
            4'h5: return mk(2'd0, 2'd0, 8'h0, 8'h0, 0, 0, 0, 4'h0, ra, 4'h0, 1, 0, p);
            default: return idle(p, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic logic [7:0] model_next(input logic [15:0] ins, input logic [7:0] p, input logic z);
        if (ins[15:12] == 4'h5 && z) return p + ins[7:0];
        if (ins[15:12] == 4'h6) return ins[7:0];
        return p;
    endfunction

    task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pc_model=%02h: got=%h want=%h", name, mpc, act, exp);
        end
    endtask

    // Entered at a falling edge in FETCH; returns at the falling edge of the next FETCH.
    task automatic step(input logic [15:0] ins, input logic z, input logic use_tbl,
                        input ctrl_t texp, input logic [7:0] tnext);
        logic [3:0] op = ins[15:12];
        rom[mpc] = ins;
        #1 check("fetch", sample(), idle(mpc, 1'b1, 1'b0));
        @(negedge clk);
        #1 check("decode", sample(), idle(mpc, 1'b0, 1'b0));
        mpc = mpc + 8'd1;
        if (op == 4'hF) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1 check("halt", sample(), idle(mpc, 1'b0, 1'b1));
            end
            return;
        end
        if (op <= 4'h6) begin
            @(negedge clk);
            bus.zero = z;
            #1 check("exec", sample(), use_tbl ? texp : model_exec(ins, mpc));
            mpc = use_tbl ? tnext : model_next(ins, mpc, z);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 check("reset", sample(), idle(8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;
    endtask

    initial begin
        ctrl_t none = '0;
        bus.zero = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        tbl[0]  = '{16'h337F, 1'b0, mk(2'd0, 2'd2, 8'h7F, 8'h00, 0, 0, 1, 4'h3, 4'h0, 4'h0, 0, 0, 8'h01), 8'h01};
        tbl[1]  = '{16'h2123, 1'b0, mk(2'd1, 2'd0, 8'h00, 8'h00, 0, 0, 1, 4'h1, 4'h2, 4'h3, 1, 1, 8'h02), 8'h02};
        tbl[2]  = '{16'h4123, 1'b0, mk(2'd2, 2'd0, 8'h00, 8'h00, 0, 0, 1, 4'h1, 4'h2, 4'h3, 1, 1, 8'h03), 8'h03};
        tbl[3]  = '{16'h1210, 1'b0, mk(2'd0, 2'd0, 8'h00, 8'h10, 0, 1, 0, 4'h0, 4'h2, 4'h0, 1, 0, 8'h04), 8'h04};
        tbl[4]  = '{16'h0310, 1'b0, mk(2'd0, 2'd1, 8'h00, 8'h10, 1, 0, 1, 4'h3, 4'h0, 4'h0, 0, 0, 8'h05), 8'h05};
        tbl[5]  = '{16'h54FD, 1'b1, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'h4, 4'h0, 1, 0, 8'h06), 8'h03};
        tbl[6]  = '{16'h6005, 1'b0, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h04), 8'h05};
        tbl[7]  = '{16'h54FD, 1'b0, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'h4, 4'h0, 1, 0, 8'h06), 8'h06};
        tbl[8]  = '{16'h60FF, 1'b0, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h07), 8'hFF};
        tbl[9]  = '{16'h3001, 1'b0, mk(2'd0, 2'd2, 8'h01, 8'h00, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00), 8'h00};
        tbl[10] = '{16'h600F, 1'b0, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h01), 8'h0F};
        tbl[11] = '{16'h5A80, 1'b1, mk(2'd0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 4'hA, 4'h0, 1, 0, 8'h10), 8'h90};
        tbl[12] = '{16'h2FED, 1'b0, mk(2'd1, 2'd0, 8'h00, 8'h00, 0, 0, 1, 4'hF, 4'hE, 4'hD, 1, 1, 8'h91), 8'h91};

        @(negedge clk);
        @(negedge clk);
        mpc = 8'h00;
        do_reset();

        // Reset asserted during the STORE execute cycle aborts the write and the PC update.
        rom[0] = 16'h1210;
        @(negedge clk);
        @(negedge clk);
        #1 check("store_exec", sample(), tbl[3].exp.d_wr ? mk(2'd0, 2'd0, 8'h00, 8'h10, 0, 1, 0, 4'h0, 4'h2, 4'h0, 1, 0, 8'h01) : none);
        rst = 1'b1;
        #1 check("rst_mid_store", sample(), idle(8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        mpc = 8'h00;

        for (int i = 0; i < 13; i++) step(tbl[i].instr, tbl[i].z, 1'b1, tbl[i].exp, tbl[i].next_pc);

        step(16'h7ABC, 1'b0, 1'b0, none, 8'h00);
        step(16'hF000, 1'b0, 1'b0, none, 8'h00);
        do_reset();

        for (int n = 0; n < 250; n++) begin
            logic [3:0]  op;
            logic [15:0] ins;
            int unsigned r = $urandom_range(0, 9);
            op  = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 14));
            ins = {op, 12'($urandom)};
            step(ins, 1'($urandom), 1'b0, none, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
